sc_regbackbank: RTL
===================

SC_REGBACKBANK -- requirements
Module: sc_regbackbank

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 8, bit width of one background row.
REQ-002 SHALL have parameter ROWS, default 4, number of rows; legal range 1..16.
REQ-003 SHALL have parameter INIT_PATTERN, default 8'b11100111, the fixed init pattern applied to every row.
REQ-004 SHALL have port SC_RegBACKBANK_CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port SC_RegBACKBANK_RESET_InLow  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port SC_RegBACKBANK_NEXTLEVEL  input  2  command: 01 load level, 10 load init, 00/11 hold.
REQ-007 SHALL have port SC_RegBACKBANK_LEVELOR  input  ROWS*DATAWIDTH_BUS  level patterns; row r occupies bits [r*W+W-1 : r*W].
REQ-008 SHALL have port SC_RegBACKBANK_DIR  input  ROWS  per-row scroll direction: 1 rotates left, 0 rotates right.
REQ-009 SHALL have port SC_RegBACKBANK_SPEED  input  8  scroll period in clock cycles; 0 stops scrolling.
REQ-010 SHALL have port SC_RegBACKBANK_data_OutBUS  output  ROWS*DATAWIDTH_BUS  registered row contents, same packing as LEVELOR.
REQ-011 SHALL have port SC_RegBACKBANK_STEP  output  1  registered one-cycle pulse, high in the cycle after each scroll step.

Function
REQ-012 SHALL apply, per clock edge, this priority: reset, then load init, then load level, then scroll step, then hold.
REQ-013 SHALL write INIT_PATTERN to every row one cycle after NEXTLEVEL=10 is sampled.
REQ-014 SHALL write each LEVELOR slice to its row one cycle after NEXTLEVEL=01 is sampled.
REQ-015 SHALL clear the prescaler to 0 on any load, and SHALL suppress the scroll step in that cycle.
REQ-016 SHALL increment an 8-bit prescaler each cycle while SPEED!=0 and no load is active.
REQ-017 SHALL issue a scroll step and clear the prescaler when prescaler >= SPEED-1; this covers SPEED lowered mid-count.
REQ-018 SHALL hold the prescaler, issue no steps, and keep the rows unchanged while SPEED=0.
REQ-019 SHALL rotate every row by exactly one bit on a scroll step, in the direction given by DIR, with wrap-around and no bit loss.
REQ-020 SHALL sample DIR in the step cycle, so a DIR change affects only later steps.
REQ-021 SHALL make the first step occur SPEED cycles after a load, and then every SPEED cycles.
REQ-022 SHALL drive STEP high for exactly one cycle per step; with SPEED=1, STEP stays high continuously.
REQ-023 SHALL treat ROWS=1 and DATAWIDTH_BUS=1 as legal; a 1-bit rotate is the identity, and STEP still pulses.

Reset
REQ-024 SHALL, while RESET_InLow=0 at a clock edge, load every row with INIT_PATTERN, clear the prescaler, and drive STEP=0.
REQ-025 SHALL let reset override any command or step in progress mid-operation; normal operation resumes on the first edge with reset high.
REQ-026 SHALL keep outputs unchanged between clock edges; there is no asynchronous path.

Configuration
REQ-027 SHALL use macro SC_REGBACKBANK_SCROLL_EN to include or exclude scrolling.
REQ-028 SHALL, with SC_REGBACKBANK_SCROLL_EN defined, implement the prescaler, the rotation and STEP as specified above.
REQ-029 SHALL, without SC_REGBACKBANK_SCROLL_EN, remove the prescaler, ignore DIR and SPEED, tie STEP to 0, and behave as a pure load/hold bank.

Structure
REQ-030 SHALL take the NEXTLEVEL command encodings (CMD_HOLD, CMD_LOAD_LEVEL, CMD_LOAD_INIT) and the default INIT_PATTERN from shared package sc_regback_pkg.
REQ-031 SHALL instantiate ROWS copies of sub-module sc_regbackrow, one row register with load/rotate-left/rotate-right/hold, via a generate loop.
REQ-032 SHALL keep the prescaler and the STEP register in the top level, shared by all rows.

Verification
REQ-033 SHALL verify reset: RESET_InLow=0 for 2 cycles -> every row = 11100111 and STEP=0.
REQ-034 SHALL verify load level: ROWS=4, LEVELOR=0xF00F_AA55, NEXTLEVEL=01 for 1 cycle -> data_OutBUS=0xF00F_AA55 on the next cycle; no step for 1 cycle.
REQ-035 SHALL verify scrolling: SPEED=3, DIR=4'b0101, row0=0x55, row1=0x0F -> after 3 cycles row0=0xAA, row1=0x87, and STEP pulses once.
REQ-036 SHALL verify simultaneous events: load init issued in the cycle a step is due -> rows = 11100111, no rotation, prescaler = 0, next step 3 cycles later.
REQ-037 SHALL verify speed change: SPEED 10->2 while the prescaler = 5 -> step on the next edge; SPEED=0 -> rows frozen for 50 cycles.
REQ-038 SHALL verify reset mid-scroll: RESET_InLow=0 during a step cycle -> rows = init, STEP=0; build without the macro -> STEP=0 for the whole run.

Source files
------------

// File: rtl/sc_regback_pkg.sv
// -----------------------------------------------------------------------------
// sc_regback_pkg
// Shared definitions for the background register bank.
//   cmd_e                 : NEXTLEVEL command encodings
//   INIT_PATTERN_DEFAULT  : default row init pattern
//   PRESC_WIDTH           : prescaler / SPEED width
//   cmdDecode()           : command -> load-select decode
// -----------------------------------------------------------------------------
package sc_regback_pkg;

  // NEXTLEVEL encodings; 2'b11 is an alias for hold.
  typedef enum logic [1:0] {
    CMD_HOLD       = 2'b00,
    CMD_LOAD_LEVEL = 2'b01,
    CMD_LOAD_INIT  = 2'b10,
    CMD_HOLD_ALT   = 2'b11
  } cmd_e;

  // Row source selected by a decoded command.
  typedef enum logic [1:0] {
    SRC_HOLD  = 2'b00,
    SRC_LEVEL = 2'b01,
    SRC_INIT  = 2'b10
  } rowSrc_e;

  localparam logic [7:0] INIT_PATTERN_DEFAULT = 8'b11100111;
  localparam int unsigned PRESC_WIDTH = 8;

  // Init outranks level; both hold encodings map to SRC_HOLD.
  function automatic rowSrc_e cmdDecode(input cmd_e cmd);
    rowSrc_e src;
    unique case (cmd)
      CMD_LOAD_INIT:  src = SRC_INIT;
      CMD_LOAD_LEVEL: src = SRC_LEVEL;
      default:        src = SRC_HOLD;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/sc_regbackrow.sv
// -----------------------------------------------------------------------------
// sc_regbackrow
// One background row register: load / rotate-left / rotate-right / hold.
// Ports:
//   SC_RegBACKROW_CLOCK_50     in   clock, rising edge
//   SC_RegBACKROW_LOAD         in   load LOADDATA (highest priority)
//   SC_RegBACKROW_LOADDATA     in   DATAWIDTH_BUS-bit value to load
//   SC_RegBACKROW_ROTATE       in   rotate by one bit this cycle
//   SC_RegBACKROW_DIR          in   1 = rotate left, 0 = rotate right
//   SC_RegBACKROW_data_OutBUS  out  registered row contents
// The row has no reset of its own: the bank turns reset into a load of the
// init pattern, so reset and load-init share one path.
// -----------------------------------------------------------------------------
module sc_regbackrow #(
  parameter int unsigned DATAWIDTH_BUS = 8
) (
  input  logic                     SC_RegBACKROW_CLOCK_50,
  input  logic                     SC_RegBACKROW_LOAD,
  input  logic [DATAWIDTH_BUS-1:0] SC_RegBACKROW_LOADDATA,
  input  logic                     SC_RegBACKROW_ROTATE,
  input  logic                     SC_RegBACKROW_DIR,
  output logic [DATAWIDTH_BUS-1:0] SC_RegBACKROW_data_OutBUS
);

  logic [DATAWIDTH_BUS-1:0] rowQ;
  logic [DATAWIDTH_BUS-1:0] rowD;
  logic [DATAWIDTH_BUS-1:0] rotLeft;
  logic [DATAWIDTH_BUS-1:0] rotRight;

  // Shift-or form stays valid for a 1-bit row, where both reduce to identity.
  assign rotLeft  = (rowQ << 1) | (rowQ >> (DATAWIDTH_BUS - 1));
  assign rotRight = (rowQ >> 1) | (rowQ << (DATAWIDTH_BUS - 1));

  always_comb begin
    rowD = rowQ;
    if (SC_RegBACKROW_LOAD) begin
      rowD = SC_RegBACKROW_LOADDATA;
    end else if (SC_RegBACKROW_ROTATE) begin
      rowD = SC_RegBACKROW_DIR ? rotLeft : rotRight;
    end
  end

  always_ff @(posedge SC_RegBACKROW_CLOCK_50) begin
    rowQ <= rowD;
  end

  assign SC_RegBACKROW_data_OutBUS = rowQ;

endmodule

// File: rtl/sc_regbackbank.sv
// -----------------------------------------------------------------------------
// sc_regbackbank
// Bank of ROWS scrolling background rows with a shared scroll prescaler.
// Ports:
//   SC_RegBACKBANK_CLOCK_50     in   sole clock, rising edge
//   SC_RegBACKBANK_RESET_InLow  in   synchronous active-low reset
//   SC_RegBACKBANK_NEXTLEVEL    in   01 load level, 10 load init, 00/11 hold
//   SC_RegBACKBANK_LEVELOR      in   level patterns, row r at [r*W +: W]
//   SC_RegBACKBANK_DIR          in   per-row direction, 1 left / 0 right
//   SC_RegBACKBANK_SPEED        in   scroll period in cycles, 0 stops
//   SC_RegBACKBANK_data_OutBUS  out  registered rows, same packing as LEVELOR
//   SC_RegBACKBANK_STEP         out  one-cycle pulse after each scroll step
// Build option: define SC_REGBACKBANK_SCROLL_EN to include scrolling. Without
// it the bank is a pure load/hold register and STEP is tied low.
// -----------------------------------------------------------------------------
module sc_regbackbank
  import sc_regback_pkg::*;
#(
  parameter int unsigned              DATAWIDTH_BUS = 8,
  parameter int unsigned              ROWS          = 4,
  parameter logic [DATAWIDTH_BUS-1:0] INIT_PATTERN  = DATAWIDTH_BUS'(INIT_PATTERN_DEFAULT)
) (
  input  logic                          SC_RegBACKBANK_CLOCK_50,
  input  logic                          SC_RegBACKBANK_RESET_InLow,
  input  logic [1:0]                    SC_RegBACKBANK_NEXTLEVEL,
  input  logic [ROWS*DATAWIDTH_BUS-1:0] SC_RegBACKBANK_LEVELOR,
  input  logic [ROWS-1:0]               SC_RegBACKBANK_DIR,
  input  logic [PRESC_WIDTH-1:0]        SC_RegBACKBANK_SPEED,
  output logic [ROWS*DATAWIDTH_BUS-1:0] SC_RegBACKBANK_data_OutBUS,
  output logic                          SC_RegBACKBANK_STEP
);

  rowSrc_e rowSrc;
  logic    loadInit;
  logic    loadLevel;
  logic    anyLoad;
  logic    stepNow;

  assign rowSrc = cmdDecode(cmd_e'(SC_RegBACKBANK_NEXTLEVEL));

  // Reset is folded into load-init so it wins over every command and step.
  assign loadInit  = !SC_RegBACKBANK_RESET_InLow || (rowSrc == SRC_INIT);
  assign loadLevel = SC_RegBACKBANK_RESET_InLow && (rowSrc == SRC_LEVEL);
  assign anyLoad   = loadInit || loadLevel;

`ifdef SC_REGBACKBANK_SCROLL_EN

  logic [PRESC_WIDTH-1:0] prescQ;
  logic [PRESC_WIDTH-1:0] prescD;
  logic                   stepQ;

  // '>=' rather than '==' so lowering SPEED mid-count steps at once instead
  // of waiting for the prescaler to wrap.
  always_comb begin
    prescD  = prescQ;
    stepNow = 1'b0;
    if (anyLoad) begin
      prescD = '0;
    end else if (SC_RegBACKBANK_SPEED != '0) begin
      if (prescQ >= (SC_RegBACKBANK_SPEED - PRESC_WIDTH'(1))) begin
        stepNow = 1'b1;
        prescD  = '0;
      end else begin
        prescD = prescQ + PRESC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge SC_RegBACKBANK_CLOCK_50) begin
    if (!SC_RegBACKBANK_RESET_InLow) begin
      prescQ <= '0;
      stepQ  <= 1'b0;
    end else begin
      prescQ <= prescD;
      stepQ  <= stepNow;
    end
  end

  assign SC_RegBACKBANK_STEP = stepQ;

`else

  logic unusedScroll;

  assign stepNow             = 1'b0;
  assign SC_RegBACKBANK_STEP = 1'b0;
  assign unusedScroll        = ^{SC_RegBACKBANK_DIR, SC_RegBACKBANK_SPEED};

`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATAWIDTH_BUS-1:0] loadData;

    assign loadData = loadInit ? INIT_PATTERN
                               : SC_RegBACKBANK_LEVELOR[r*DATAWIDTH_BUS +: DATAWIDTH_BUS];

    sc_regbackrow #(
      .DATAWIDTH_BUS(DATAWIDTH_BUS)
    ) u_row (
      .SC_RegBACKROW_CLOCK_50   (SC_RegBACKBANK_CLOCK_50),
      .SC_RegBACKROW_LOAD       (anyLoad),
      .SC_RegBACKROW_LOADDATA   (loadData),
      .SC_RegBACKROW_ROTATE     (stepNow),
      .SC_RegBACKROW_DIR        (SC_RegBACKBANK_DIR[r]),
      .SC_RegBACKROW_data_OutBUS(SC_RegBACKBANK_data_OutBUS[r*DATAWIDTH_BUS +: DATAWIDTH_BUS])
    );
  end

endmodule
